sdf_stage_ctrl: RTL and testbench

//  Sequencer for one radix-2 single-path delay-feedback (SDF) FFT stage.

---
 rtl/sdf_stage_ctrl.sv | 108 ++++++++++
 tb/tb_sdf_stage_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl: sequencer for one radix-2 single-path delay-feedback FFT stage
//
// Counts samples within each 2*HALF-sample frame. For every accepted sample it
// decodes the stage mode, the twiddle ROM address, the delay-line write enable
// and the output-valid strobe. At end of stream it drains the delay line.
//
// Ports
//   clk        clock
//   rst_n      async active-low reset
//   in_valid   upstream sample valid
//   in_last    with in_valid: last sample of the last frame
//   in_ready   stage accepts a sample this cycle
//   mode       0 FILL, 1 BFLY, 2 TWID for this cycle's sample
//   tw_addr    twiddle ROM address, 0 (W=1) unless mode is TWID
//   delay_we   delay line shifts this cycle
//   out_valid  stage output sample valid this cycle
//   out_last   last drained output sample
//   busy       sequencer not idle
//   frame_cnt  frames completed since stream start
//   done       one-cycle pulse the cycle after out_last
//   err        one-cycle pulse on a misplaced in_last
module sdf_stage_ctrl #(
  parameter int HALF    = 64,
  parameter int ROM_AW  = 6,
  parameter int TW_STEP = 1,
  parameter int FRAME_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [1:0]         mode,
  output logic [ROM_AW-1:0]  tw_addr,
  output logic               delay_we,
  output logic               out_valid,
  output logic               out_last,
  output logic               busy,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               done,
  output logic               err
);
  localparam int AW = $clog2(HALF);
  localparam logic [AW:0] CNT_HM1 = (AW+1)'(HALF - 1);
  localparam logic [AW:0] CNT_FM1 = (AW+1)'(2 * HALF - 1);
  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
  state_t state, state_nx;
  logic [AW:0] cnt, cnt_nx;
  logic [FRAME_W-1:0] frame_nx;
  logic acc, adv, frame_end, done_nx, err_nx;
  assign in_ready  = rst_n & (state != FLUSH);
  assign acc       = in_valid & in_ready;
  // the drain runs free: no upstream samples are needed to empty the delay line
  assign adv       = (state == FLUSH) | acc;
  assign frame_end = cnt == CNT_FM1;
  // in RUN the top count bit separates the second (butterfly) half of a frame
  assign mode      = state == RUN ? (cnt[AW] ? 2'd1 : 2'd2) : state == FLUSH ? 2'd2 : 2'd0;
  assign tw_addr   = mode == 2'd2 ? ROM_AW'(cnt[AW-1:0] * TW_STEP) : '0;
  assign delay_we  = adv;
  assign out_valid = (state == FLUSH) | ((state == RUN) & acc);
  assign out_last  = (state == FLUSH) & (cnt == CNT_HM1);
  assign busy      = state != IDLE;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    frame_nx = frame_cnt;
    done_nx  = 1'b0;
    err_nx   = acc & in_last & ~((state == RUN) & frame_end);
    case (state)
      IDLE: if (acc) begin
        state_nx = FILL;
        cnt_nx   = (AW+1)'(1);
        frame_nx = '0;
      end
      FILL: if (acc) begin
        cnt_nx   = cnt + 1'b1;
        state_nx = cnt == CNT_HM1 ? RUN : FILL;
      end
      RUN: if (acc) begin
        // 2*HALF is a power of two, so the increment wraps at the frame end
        cnt_nx   = cnt + 1'b1;
        frame_nx = frame_end ? frame_cnt + 1'b1 : frame_cnt;
        state_nx = frame_end & in_last ? FLUSH : RUN;
      end
      FLUSH: begin
        cnt_nx   = out_last ? '0 : cnt + 1'b1;
        state_nx = out_last ? IDLE : FLUSH;
        done_nx  = out_last;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      frame_cnt <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      frame_cnt <= frame_nx;
      done      <= done_nx;
      err       <= err_nx;
    end
  end
endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// tb_sdf_stage_ctrl: randomized bench for sdf_stage_ctrl against a sample-index model, HALF=64/STEP=1 and HALF=32/STEP=2
module tb_sdf_stage_ctrl;
  logic clk = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int n_fin = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int H  = g ? 32 : 64;
    localparam int TS = g ? 2 : 1;
    logic rst_n, in_valid, in_last, in_ready, delay_we, out_valid, out_last, busy, done, err;
    logic [1:0] mode;
    logic [5:0] tw_addr;
    logic [15:0] frame_cnt;
    int ph, k, f, fc;
    bit ed, ee;
    sdf_stage_ctrl #(.HALF(H), .ROM_AW(6), .TW_STEP(TS), .FRAME_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .mode(mode), .tw_addr(tw_addr), .delay_we(delay_we), .out_valid(out_valid),
      .out_last(out_last), .busy(busy), .frame_cnt(frame_cnt), .done(done), .err(err)
    );
    task automatic step(input bit v, input bit l);
      int pos, em, et;
      bit acc, fin;
      string p;
      p = $sformatf("h%0d:", H);
      in_valid = v;
      in_last = l;
      @(negedge clk);
      acc = v && ph != 2;
      pos = k % (2 * H);
      em = ph == 2 ? 2 : k < H ? 0 : pos < H ? 2 : 1;
      et = ph == 2 ? f * TS : em == 2 ? pos * TS : 0;
      chk({p, "in_ready"}, int'(in_ready), int'(ph != 2));
      chk({p, "mode"}, int'(mode), em);
      chk({p, "tw_addr"}, int'(tw_addr), et);
      chk({p, "delay_we"}, int'(delay_we), int'(ph == 2 || acc));
      chk({p, "out_valid"}, int'(out_valid), int'(ph == 2 || (em != 0 && acc)));
      chk({p, "out_last"}, int'(out_last), int'(ph == 2 && f == H - 1));
      chk({p, "busy"}, int'(busy), int'(ph != 0));
      chk({p, "frame_cnt"}, int'(frame_cnt), fc);
      chk({p, "done"}, int'(done), int'(ed));
      chk({p, "err"}, int'(err), int'(ee));
      fin = acc && l && pos == 2 * H - 1;
      ee = acc && l && !fin;
      ed = ph == 2 && f == H - 1;
      if (ph == 2) begin
        f++;
        if (f == H) begin
          ph = 0;
          k = 0;
        end
      end else if (acc) begin
        if (ph == 0) begin
          ph = 1;
          fc = 0;
        end
        if (pos == 2 * H - 1) fc = (fc + 1) % 65536;
        k++;
        if (fin) begin
          ph = 2;
          f = 0;
        end
      end
      @(posedge clk);
      #1;
    endtask
    task automatic rst_do();
      string p;
      p = $sformatf("h%0d:rst_", H);
      rst_n = 1'b0;
      in_valid = 1'b1;
      in_last = 1'b0;
      #1;
      chk({p, "in_ready"}, int'(in_ready), 0);
      chk({p, "out_valid"}, int'(out_valid), 0);
      chk({p, "delay_we"}, int'(delay_we), 0);
      chk({p, "busy"}, int'(busy), 0);
      chk({p, "mode"}, int'(mode), 0);
      chk({p, "tw_addr"}, int'(tw_addr), 0);
      chk({p, "out_last"}, int'(out_last), 0);
      chk({p, "frame_cnt"}, int'(frame_cnt), 0);
      chk({p, "done"}, int'(done), 0);
      chk({p, "err"}, int'(err), 0);
      ph = 0; k = 0; f = 0; fc = 0; ed = 0; ee = 0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
    endtask
    task automatic stream(input int n, input int bub, input int mis, input int rst_at);
      int s, i, b;
      bit v, a;
      string p;
      p = $sformatf("h%0d:", H);
      s = 0;
      i = 0;
      while (s < n && i < 16 * n) begin
        if (bub == 0) v = 1'b1;
        else if (bub == 1) v = (i % 2) == 0;
        else v = $urandom_range(0, 9) < 7;
        a = v && ph != 2;
        step(v, v && (s == n - 1 || s == mis));
        s += int'(a);
        i++;
      end
      chk({p, "stream_len"}, s, n);
      b = 0;
      while (ph != 0 && b < 4 * H) begin
        if (ph == 2 && f == rst_at) rst_do();
        else step(1'b0, 1'b0);
        b++;
      end
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
    endtask
    initial begin
      int n, mis, ra;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_last = 1'b0;
      ph = 0; k = 0; f = 0; fc = 0; ed = 0; ee = 0;
      @(posedge clk);
      #1;
      rst_do();
      stream(2 * H, 0, -1, -1);
      stream(4 * H, 0, -1, -1);
      stream(2 * H, 1, -1, -1);
      stream(4 * H, 0, H + 6, -1);
      stream(2 * H, 0, -1, 10);
      stream(2 * H, 0, 0, -1);
      for (int r = 0; r < 10; r++) begin
        n = 2 * H * int'($urandom_range(1, 3));
        mis = $urandom_range(0, 2) == 0 ? int'($urandom_range(0, n - 2)) : -1;
        if (mis % (2 * H) == 2 * H - 1) mis--;
        ra = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, H - 1)) : -1;
        stream(n, 2, mis, ra);
      end
      n_fin++;
    end
  end
  initial begin
    for (int i = 0; i < 200000 && n_fin < 2; i++) @(posedge clk);
    chk("finished", n_fin, 2);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
